// File: rtl/vcve2_dmem_pkg.sv
// Shared types and constants for the vcve2 data-memory responder.
// Contents: response pipeline entry struct, grant-stall LFSR constants.
package vcve2_dmem_pkg;

    // One response pipeline slot; a bubble is all zeros.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } dmem_resp_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10.
    localparam int unsigned LfsrWidth      = 16;
    localparam logic [15:0] LfsrSeed       = 16'hACE1;
    localparam logic [15:0] LfsrTaps       = 16'hB400;

    // A held request is stalled for at most this many consecutive cycles.
    localparam int unsigned MaxStallCycles = 3;
    localparam int unsigned StallCntWidth  = 2;

endpackage

// File: rtl/vcve2_dmem_responder_if.sv
// Core data-memory req/gnt/rvalid bus.
// master: initiator (drives req, we, be, addr, wdata)
// slave : responder (drives gnt, rvalid, rdata, err)
interface vcve2_dmem_responder_if;

    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/vcve2_dmem_lfsr.sv
// 16-bit Fibonacci LFSR used to pseudo-randomly stall grants.
// Ports: clk_i, rst_ni (async, active-low, loads seed), en_i (advance),
//        state_o (current register state).
module vcve2_dmem_lfsr
    import vcve2_dmem_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    output logic [LfsrWidth-1:0] state_o
);

    // Shift left, feedback is the XOR of the tapped bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_o <= LfsrSeed;
        end else if (en_i) begin
            state_o <= {state_o[LfsrWidth-2:0], ^(state_o & LfsrTaps)};
        end
    end

endmodule

// File: rtl/vcve2_dmem_responder.sv
// Data-memory responder: word SRAM model with byte enables, fixed
// pipelined response latency and address-range/alignment error detection.
// Ports: clk_i, rst_ni (async, active-low), bus (slave side of the dmem bus).
// Optional build macro VCVE2_DMEM_GNT_STALL_EN adds LFSR-driven grant stalls
// (a held request is still granted within MaxStallCycles+1 cycles).
module vcve2_dmem_responder
    import vcve2_dmem_pkg::*;
#(
    parameter int unsigned MemWords    = 1024,
    parameter logic [31:0] BaseAddr    = 32'h0010_0000,
    parameter int unsigned RespLatency = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    vcve2_dmem_responder_if.slave   bus
);

    localparam int unsigned IdxW = $clog2(MemWords);

    logic [31:0]     mem_q [MemWords];
    dmem_resp_t      pipe_q [RespLatency];
    dmem_resp_t      entry_c;
    logic            stall_c;
    logic            accept_c;
    logic            addr_err_c;
    logic [IdxW-1:0] idx_c;

`ifdef VCVE2_DMEM_GNT_STALL_EN
    logic [LfsrWidth-1:0]     lfsr_state;
    logic [StallCntWidth-1:0] stall_cnt_q;

    vcve2_dmem_lfsr u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (1'b1),
        .state_o (lfsr_state)
    );

    // Stall is capped so a held request cannot starve.
    assign stall_c = (lfsr_state[1:0] == 2'b00) &&
                     (stall_cnt_q < StallCntWidth'(MaxStallCycles));

    // Counts consecutive stalled cycles with a pending request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (bus.req && stall_c) begin
            stall_cnt_q <= stall_cnt_q + StallCntWidth'(1);
        end else begin
            stall_cnt_q <= '0;
        end
    end
`else
    assign stall_c = 1'b0;
`endif

    // Grant is combinational so a request can be accepted in its first cycle.
    assign bus.gnt  = bus.req && !stall_c;
    assign accept_c = bus.req && !stall_c;

    // Base is aligned to the array size, so range check reduces to upper bits.
    assign addr_err_c = (bus.addr[31:IdxW+2] != BaseAddr[31:IdxW+2]) ||
                        (bus.addr[1:0] != 2'b00);
    assign idx_c      = bus.addr[IdxW+1:2];

    // Response entry for this cycle; bubbles and non-read responses carry rdata 0.
    always_comb begin
        entry_c = '0;
        if (accept_c) begin
            entry_c.valid = 1'b1;
            entry_c.err   = addr_err_c;
            if (!addr_err_c && !bus.we) begin
                entry_c.rdata = mem_q[idx_c];
            end
        end
    end

    // Byte-enabled write; array is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (accept_c && bus.we && !addr_err_c) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus.be[b]) begin
                    mem_q[idx_c][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Fixed-latency response shift register; reset drops in-flight responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RespLatency; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= entry_c;
            for (int unsigned i = 1; i < RespLatency; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.rvalid = pipe_q[RespLatency-1].valid;
    assign bus.err    = pipe_q[RespLatency-1].err;
    assign bus.rdata  = pipe_q[RespLatency-1].rdata;

endmodule
